// File: rtl/mult_seq_if.sv
// mult_seq_if -- handshake and data bundle for the sequential multiplier.
//
// Signals (N = operand width):
//   start    request to begin a product
//   abort    cancel the product in progress
//   g_input  N-bit multiplicand, taken on the accepting edge
//   e_input  N-bit multiplier, taken on the accepting edge
//   busy     high while a product is being accumulated
//   done     one-cycle pulse when o holds a fresh product
//   o        2N-bit product, held until the next done or reset
//
// Modports: master drives requests and operands; slave is the multiplier.
interface mult_seq_if #(
   parameter int N = 128
);
   logic           start;
   logic           abort;
   logic [N-1:0]   g_input;
   logic [N-1:0]   e_input;
   logic           busy;
   logic           done;
   logic [2*N-1:0] o;

   modport master (
      output start, abort, g_input, e_input,
      input  busy, done, o
   );

   modport slave (
      input  start, abort, g_input, e_input,
      output busy, done, o
   );
endinterface

// File: rtl/mult_seq.sv
// mult_seq -- multi-cycle N x N multiplier producing a 2N-bit product in CC
// clock cycles by consuming the multiplier W = N/CC bits at a time.
//
// Ports:
//   clk  single clock, rising-edge
//   rst  synchronous active-low reset
//   bus  mult_seq_if.slave (start, abort, g_input, e_input, busy, done, o)
//
// Parameters:
//   N   operand width (must be a multiple of CC)
//   CC  cycles per product
//
// Configuration macro MULT_SEQ_SIGNED_EN: when defined, operands and product
// are two's-complement; otherwise the datapath is purely unsigned.
module mult_seq #(
   parameter int N  = 128,
   parameter int CC = 4
) (
   input  logic      clk,
   input  logic      rst,
   mult_seq_if.slave bus
);

   localparam int W     = N / CC;
   localparam int AW    = 2 * N;
   localparam int PW    = N + W;
   localparam int CNT_W = (CC > 1) ? $clog2(CC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CC - 1);

   if ((N % CC) != 0 || CC < 1) begin : g_param_check
      $error("mult_seq: N must be a positive multiple of CC");
   end

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            load;
   logic            step;
   logic            finish;

   logic [N-1:0]    g_reg;
   logic [N-1:0]    e_reg;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   o_reg;
   logic [CNT_W-1:0] cnt;

   logic [PW-1:0]   partial;
   logic [AW-1:0]   placed;
   logic [AW-1:0]   sum;
   logic [AW-1:0]   acc_shift;
   logic            last_chunk;

`ifdef MULT_SEQ_SIGNED_EN
   // g is sign-extended to N+W bits. Lower chunks of e are unsigned digits;
   // the top chunk is a signed digit, so its sign bit carries weight
   // -2^(W-1) and the partial product is subtracted rather than added.
   function automatic logic [PW-1:0] partial_prod(
      input logic [N-1:0] g,
      input logic [W-1:0] chunk,
      input logic         last
   );
      logic signed [PW-1:0] g_ext;
      logic signed [W:0]    chunk_s;
      logic signed [PW-1:0] prod;
      g_ext   = PW'($signed(g));
      chunk_s = last ? $signed({chunk[W-1], chunk}) : $signed({1'b0, chunk});
      prod    = g_ext * PW'(chunk_s);
      return prod;
   endfunction
`else
   // Unsigned digit product; g*chunk < 2^(N+W) so nothing is lost.
   function automatic logic [PW-1:0] partial_prod(
      input logic [N-1:0] g,
      input logic [W-1:0] chunk
   );
      return PW'(g) * PW'(chunk);
   endfunction
`endif

   assign last_chunk = (cnt == LAST);

   // Partial product lands at bit N-W of the accumulator; after the
   // remaining shifts the first digit's LSB ends up at bit 0, so the bits
   // dropped by the right shift are always zero.
`ifdef MULT_SEQ_SIGNED_EN
   assign partial   = partial_prod(g_reg, e_reg[W-1:0], last_chunk);
   assign placed    = AW'($signed(partial)) << (N - W);
   assign sum       = acc + placed;
   assign acc_shift = $signed(sum) >>> W;
`else
   assign partial   = partial_prod(g_reg, e_reg[W-1:0]);
   assign placed    = AW'(partial) << (N - W);
   assign sum       = acc + placed;
   assign acc_shift = sum >> W;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath control; abort outranks the final step
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_next = IDLE;
            end else if (last_chunk) begin
               finish     = 1'b1;
               state_next = DONE;
            end else begin
               step = 1'b1;
            end
         end
         DONE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand, accumulator, counter and result registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         g_reg <= '0;
         e_reg <= '0;
         acc   <= '0;
         cnt   <= '0;
         o_reg <= '0;
      end else begin
         if (load) begin
            g_reg <= bus.g_input;
            e_reg <= bus.e_input;
            acc   <= '0;
            cnt   <= '0;
         end
         if (step) begin
            acc   <= acc_shift;
            e_reg <= e_reg >> W;
            cnt   <= cnt + CNT_W'(1);
         end
         if (finish) begin
            o_reg <= sum;
         end
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.o    = o_reg;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq -- directed bench for mult_seq with N=8 at CC=4 and CC=1.
// Expected products come from a hand-computed vector table (unsigned and
// signed columns, chosen by MULT_SEQ_SIGNED_EN) plus hand-written sequences
// for back-to-back, abort, reset-in-flight and start-ignored cases.
module tb_mult_seq;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   mult_seq_if #(.N(8)) bus4 ();
   mult_seq_if #(.N(8)) bus1 ();

   mult_seq #(.N(8), .CC(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   mult_seq #(.N(8), .CC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  g;
      logic [7:0]  e;
      logic [15:0] exp_u;
      logic [15:0] exp_s;
   } vec_t;

   vec_t vecs [9];

   function automatic logic [15:0] pick(input vec_t v);
`ifdef MULT_SEQ_SIGNED_EN
      return v.exp_s;
`else
      return v.exp_u;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept edge, then CC busy cycles, then the done cycle
   task automatic run4(input logic [7:0] g, input logic [7:0] e,
                       input logic [15:0] exp, input string name);
      logic busy_ok;
      @(negedge clk);
      bus4.start   = 1'b1;
      bus4.g_input = g;
      bus4.e_input = e;
      tick();
      bus4.start = 1'b0;
      busy_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (!(bus4.busy === 1'b1 && bus4.done === 1'b0)) busy_ok = 1'b0;
         tick();
      end
      check({name, " busy window"}, 32'(busy_ok), 32'd1);
      check({name, " done"}, 32'(bus4.done), 32'd1);
      check({name, " busy low"}, 32'(bus4.busy), 32'd0);
      check({name, " o"}, 32'(bus4.o), 32'(exp));
   endtask

   task automatic start4(input logic [7:0] g, input logic [7:0] e);
      @(negedge clk);
      bus4.start   = 1'b1;
      bus4.g_input = g;
      bus4.e_input = e;
      tick();
      bus4.start = 1'b0;
   endtask

   task automatic no_done4(input int cycles, input string name);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         if (bus4.done !== 1'b0) seen++;
         tick();
      end
      check(name, 32'(seen), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      //          g      e      unsigned   signed
      vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 16'h0001};
      vecs[1] = '{8'h0D, 8'h0B, 16'h008F, 16'h008F};
      vecs[2] = '{8'h00, 8'h5A, 16'h0000, 16'h0000};
      vecs[3] = '{8'h01, 8'hFF, 16'h00FF, 16'hFFFF};
      vecs[4] = '{8'h80, 8'h80, 16'h4000, 16'h4000};
      vecs[5] = '{8'h12, 8'h34, 16'h03A8, 16'h03A8};
      vecs[6] = '{8'hAB, 8'hCD, 16'h88EF, 16'h10EF};
      vecs[7] = '{8'hFF, 8'h02, 16'h01FE, 16'hFFFE};
      vecs[8] = '{8'h7F, 8'h80, 16'h3F80, 16'hC080};

      rst = 1'b0;
      bus4.start = 1'b0; bus4.abort = 1'b0; bus4.g_input = '0; bus4.e_input = '0;
      bus1.start = 1'b0; bus1.abort = 1'b0; bus1.g_input = '0; bus1.e_input = '0;
      repeat (3) tick();
      check("reset busy", 32'(bus4.busy), 32'd0);
      check("reset done", 32'(bus4.done), 32'd0);
      check("reset o", 32'(bus4.o), 32'd0);
      check("reset o cc1", 32'(bus1.o), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) begin
         run4(vecs[i].g, vecs[i].e, pick(vecs[i]), $sformatf("vec%0d", i));
      end

      // CC=1: done on the cycle right after acceptance
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus1.start   = 1'b1;
         bus1.g_input = vecs[1 - i].g;
         bus1.e_input = vecs[1 - i].e;
         tick();
         bus1.start = 1'b0;
         check($sformatf("cc1 v%0d busy", i), 32'(bus1.busy), 32'd1);
         check($sformatf("cc1 v%0d no early done", i), 32'(bus1.done), 32'd0);
         tick();
         check($sformatf("cc1 v%0d done", i), 32'(bus1.done), 32'd1);
         check($sformatf("cc1 v%0d o", i), 32'(bus1.o), 32'(pick(vecs[1 - i])));
      end

      // Back-to-back: start held into DONE (with abort, which must not matter)
      tick();
      start4(8'd3, 8'd5);
      repeat (3) tick();
      bus4.start = 1'b1; bus4.g_input = 8'd7; bus4.e_input = 8'd9;
      tick();
      check("b2b first done", 32'(bus4.done), 32'd1);
      check("b2b first o", 32'(bus4.o), 32'd15);
      bus4.abort = 1'b1;
      tick();
      check("b2b rerun busy", 32'(bus4.busy), 32'd1);
      check("b2b rerun done low", 32'(bus4.done), 32'd0);
      bus4.start = 1'b0; bus4.abort = 1'b0;
      repeat (3) tick();
      check("b2b no early done", 32'(bus4.done), 32'd0);
      check("b2b still busy", 32'(bus4.busy), 32'd1);
      tick();
      check("b2b second done", 32'(bus4.done), 32'd1);
      check("b2b second o", 32'(bus4.o), 32'd63);

      // Abort on cycle 2
      tick();
      start4(8'd2, 8'd3);
      tick();
      bus4.abort = 1'b1;
      tick();
      bus4.abort = 1'b0;
      check("abort busy", 32'(bus4.busy), 32'd0);
      no_done4(6, "abort no done");
      check("abort o kept", 32'(bus4.o), 32'd63);

      // Abort coinciding with the final step wins
      start4(8'd2, 8'd3);
      repeat (3) tick();
      bus4.abort = 1'b1;
      tick();
      bus4.abort = 1'b0;
      check("late abort busy", 32'(bus4.busy), 32'd0);
      no_done4(6, "late abort no done");
      check("late abort o kept", 32'(bus4.o), 32'd63);

      // Reset on cycle 2 discards the product and clears o
      start4(8'd2, 8'd3);
      tick();
      rst = 1'b0;
      bus4.start = 1'b1;
      tick();
      rst = 1'b1;
      bus4.start = 1'b0;
      check("rst run busy", 32'(bus4.busy), 32'd0);
      check("rst run o", 32'(bus4.o), 32'd0);
      no_done4(6, "rst run no done");
      check("rst run idle", 32'(bus4.busy), 32'd0);

      // Start pulses during RUN with new operands are ignored
      start4(8'h12, 8'h34);
      for (int i = 0; i < 3; i++) begin
         bus4.start   = 1'b1;
         bus4.g_input = 8'hFF;
         bus4.e_input = 8'hF0 + 8'(i);
         tick();
         bus4.start = 1'b0;
      end
      tick();
      check("ignore done", 32'(bus4.done), 32'd1);
      check("ignore o", 32'(bus4.o), 32'h03A8);
      tick();
      check("ignore then idle done", 32'(bus4.done), 32'd0);
      check("ignore then idle busy", 32'(bus4.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
